unidade_min_ctrl: RTL and testbench

//  Units-of-minutes digit of the stopwatch: a mod-(MAX_COUNT+1) BCD counter.

---
 rtl/unidade_min_ctrl.sv | 143 ++++++++++++++
 tb/tb_unidade_min_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/unidade_min_ctrl.sv
// unidade_min_ctrl
// Units-of-minutes digit of the stopwatch. This block is a mod-(MAX_COUNT+1)
// BCD counter. It advances on a one-cycle TICK pulse from the seconds stage
// and contains the IDLE/RUN/PAUSE control FSM. It also drives its own
// 7-segment digit. CARRY feeds the tens-of-minutes stage.
//
// Parameters
//   MAX_COUNT       last value before wrap (1..15); count runs 0..MAX_COUNT
//   SEG_ACTIVE_LOW  1: segment lit when output is 0; 0: lit when output is 1
// Ports
//   CLK_IN   in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   TICK     in   one-minute pulse, one CLK_IN cycle wide
//   START    in   level: enter RUN from IDLE/PAUSE
//   STOP     in   level: RUN -> PAUSE
//   CLR      in   synchronous clear to IDLE, count 0
//   LOAD     in   preset count from DIN (IDLE/PAUSE only)
//   DIN      in   [3:0] preset value, saturated to MAX_COUNT
//   COUNT    out  [3:0] registered digit value
//   CARRY    out  registered one-cycle pulse after each MAX_COUNT->0 wrap
//   RUNNING  out  high while the FSM is in RUN
//   a..g     out  7-segment outputs decoded from the COUNT register
module unidade_min_ctrl #(
  parameter int MAX_COUNT      = 9,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       TICK,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLR,
  input  logic       LOAD,
  input  logic [3:0] DIN,
  output logic [3:0] COUNT,
  output logic       CARRY,
  output logic       RUNNING,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam logic [3:0] MAX_V = 4'(MAX_COUNT);

  // A preset above the top of the count range is clamped to MAX_COUNT.
  function automatic logic [3:0] sat_load(input logic [3:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Returns the lit set {a,b,c,d,e,f,g} with 1 = lit. Codes 10..15 are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] lit;
    case (v)
      4'd0:    lit = 7'b1111110;
      4'd1:    lit = 7'b0110000;
      4'd2:    lit = 7'b1101101;
      4'd3:    lit = 7'b1111001;
      4'd4:    lit = 7'b0110011;
      4'd5:    lit = 7'b1011011;
      4'd6:    lit = 7'b1011111;
      4'd7:    lit = 7'b1110000;
      4'd8:    lit = 7'b1111111;
      4'd9:    lit = 7'b1111011;
      default: lit = 7'b0000000;
    endcase
    return lit;
  endfunction

  logic [1:0] state_p0;
  logic [1:0] state_nxt;
  logic [3:0] count_p0;
  logic [3:0] count_nxt;
  logic       carry_p0;
  logic       carry_nxt;
  logic [6:0] seg_lit;
  logic [6:0] seg_out;

  // Control FSM. The priority is CLR > STOP > START. STOP wins over START
  // even in PAUSE, so pressing both holds the pause.
  always_comb begin
    state_nxt = state_p0;
    if (CLR) begin
      state_nxt = IDLE;
    end else if (STOP) begin
      if (state_p0 == RUN) state_nxt = PAUSE;
    end else if (START) begin
      if (state_p0 == IDLE || state_p0 == PAUSE) state_nxt = RUN;
    end
    if (state_p0 == 2'd3) state_nxt = IDLE;
  end

  // Counting depends on the registered state. A TICK that arrives together
  // with STOP is still counted. A TICK that arrives together with the START
  // that leaves IDLE/PAUSE is not counted.
  always_comb begin
    count_nxt = count_p0;
    carry_nxt = 1'b0;
    if (CLR) begin
      count_nxt = 4'd0;
    end else if (state_p0 == RUN) begin
      if (TICK) begin
        if (count_p0 >= MAX_V) begin
          count_nxt = 4'd0;
          carry_nxt = 1'b1;
        end else begin
          count_nxt = count_p0 + 4'd1;
        end
      end
    end else if (LOAD) begin
      count_nxt = sat_load(DIN);
    end
  end

  // Stage p0: state, digit and carry registers
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state_p0 <= IDLE;
      count_p0 <= 4'd0;
      carry_p0 <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      count_p0 <= count_nxt;
      carry_p0 <= carry_nxt;
    end
  end

  assign seg_lit = seg_decode(count_p0);
  assign seg_out = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;

  assign COUNT   = count_p0;
  assign CARRY   = carry_p0;
  assign RUNNING = (state_p0 == RUN);
  assign {a, b, c, d, e, f, g} = seg_out;

endmodule

// File: tb/tb_unidade_min_ctrl.sv
module tb_unidade_min_ctrl;

  logic       CLK_IN = 1'b0;
  logic       RST = 1'b1;
  logic       TICK = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       CLR = 1'b0;
  logic       LOAD = 1'b0;
  logic [3:0] DIN = 4'd0;
  logic [3:0] COUNT;
  logic       CARRY;
  logic       RUNNING;
  logic       a, b, c, d, e, f, g;
  logic [6:0] seg;

  int n_cmp = 0;
  int n_bad = 0;

  unidade_min_ctrl #(.MAX_COUNT(9), .SEG_ACTIVE_LOW(1'b1)) dut (
    .CLK_IN(CLK_IN), .RST(RST), .TICK(TICK), .START(START), .STOP(STOP),
    .CLR(CLR), .LOAD(LOAD), .DIN(DIN), .COUNT(COUNT), .CARRY(CARRY),
    .RUNNING(RUNNING), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  always #5 CLK_IN = ~CLK_IN;

  assign seg = {a, b, c, d, e, f, g};

  // Active-low segment patterns {a..g} for the digits 0..9.
  logic [6:0] seg_exp [0:9];
  initial begin
    seg_exp[0] = 7'b0000001; seg_exp[1] = 7'b1001111;
    seg_exp[2] = 7'b0010010; seg_exp[3] = 7'b0000110;
    seg_exp[4] = 7'b1001100; seg_exp[5] = 7'b0100100;
    seg_exp[6] = 7'b0100000; seg_exp[7] = 7'b0001111;
    seg_exp[8] = 7'b0000000; seg_exp[9] = 7'b0000100;
  end

  typedef struct {
    logic       clr, stop, start, load, tick;
    logic [3:0] din;
    logic [3:0] exp_count;
    logic       exp_carry;
    logic       exp_run;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] cnt, input logic cy, input logic run);
    check({tag, ".count"}, {4'd0, COUNT}, {4'd0, cnt});
    check({tag, ".carry"}, {7'd0, CARRY}, {7'd0, cy});
    check({tag, ".running"}, {7'd0, RUNNING}, {7'd0, run});
    check({tag, ".seg"}, {1'b0, seg}, {1'b0, seg_exp[cnt]});
  endtask

  task automatic step(input logic clr, stop, start, load, tick, input logic [3:0] din);
    CLR = clr; STOP = stop; START = start; LOAD = load; TICK = tick; DIN = din;
    @(posedge CLK_IN);
    #1;
    CLR = 0; STOP = 0; START = 0; LOAD = 0; TICK = 0;
  endtask

  initial begin
    // clr stop start load tick din | count carry run
    vecs.push_back('{0,0,0,0,0,4'd0,  4'd0,0,0});
    vecs.push_back('{0,0,0,1,0,4'd13, 4'd9,0,0}); // load saturates in IDLE
    vecs.push_back('{0,0,0,0,1,4'd0,  4'd9,0,0}); // tick ignored in IDLE
    vecs.push_back('{0,0,0,1,0,4'd3,  4'd3,0,0});
    vecs.push_back('{0,0,1,0,1,4'd0,  4'd3,0,1}); // tick with START not counted
    vecs.push_back('{0,0,0,0,1,4'd0,  4'd4,0,1});
    vecs.push_back('{0,0,0,1,0,4'd2,  4'd4,0,1}); // load ignored in RUN
    vecs.push_back('{0,1,0,0,1,4'd0,  4'd5,0,0}); // STOP+TICK counts
    vecs.push_back('{0,0,0,0,1,4'd0,  4'd5,0,0}); // paused
    vecs.push_back('{0,0,0,0,1,4'd0,  4'd5,0,0});
    vecs.push_back('{0,0,0,1,0,4'd13, 4'd9,0,0});
    vecs.push_back('{0,0,0,1,0,4'd7,  4'd7,0,0});
    vecs.push_back('{0,1,1,0,0,4'd0,  4'd7,0,0}); // STOP+START in PAUSE holds
    vecs.push_back('{0,0,1,1,0,4'd9,  4'd9,0,1}); // LOAD+START
    vecs.push_back('{0,0,0,0,1,4'd0,  4'd0,1,1}); // wrap
    vecs.push_back('{0,0,0,0,0,4'd0,  4'd0,0,1});
    vecs.push_back('{0,0,1,0,1,4'd0,  4'd1,0,1}); // START in RUN: tick counts
    vecs.push_back('{1,0,0,1,1,4'd5,  4'd0,0,0}); // CLR beats TICK and LOAD
    vecs.push_back('{0,0,0,1,0,4'd9,  4'd9,0,0});
    vecs.push_back('{0,0,1,0,0,4'd0,  4'd9,0,1});
    vecs.push_back('{1,0,0,0,1,4'd0,  4'd0,0,0}); // CLR+TICK at 9: no carry
    vecs.push_back('{0,0,0,0,0,4'd0,  4'd0,0,0});

    // Reset held, then released
    #12;
    check_outs("rst_held", 4'd0, 1'b0, 1'b0);
    @(negedge CLK_IN);
    RST = 1'b0;
    @(posedge CLK_IN); #1;
    check_outs("rst_rel", 4'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].stop, vecs[i].start, vecs[i].load, vecs[i].tick, vecs[i].din);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_carry, vecs[i].exp_run);
    end

    // 12 ticks spaced 3 cycles from 0
    step(1, 0, 0, 0, 0, 4'd0);
    step(0, 0, 1, 0, 0, 4'd0);
    check_outs("run_start", 4'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 0, 0, 1, 4'd0);
      check_outs($sformatf("tick%0d", i), 4'(i % 10), (i == 10), 1'b1);
      step(0, 0, 0, 0, 0, 4'd0);
      check_outs($sformatf("gap%0d_a", i), 4'(i % 10), 1'b0, 1'b1);
      step(0, 0, 0, 0, 0, 4'd0);
      check_outs($sformatf("gap%0d_b", i), 4'(i % 10), 1'b0, 1'b1);
    end

    // Asynchronous reset mid-RUN at count 6
    step(1, 0, 0, 0, 0, 4'd0);
    step(0, 0, 0, 1, 0, 4'd6);
    step(0, 0, 1, 0, 0, 4'd0);
    check_outs("pre_async", 4'd6, 1'b0, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    check_outs("async_rst", 4'd0, 1'b0, 1'b0);
    @(negedge CLK_IN);
    RST = 1'b0;

    // Reset drops a carry pulse in flight
    step(0, 0, 0, 1, 0, 4'd9);
    step(0, 0, 1, 0, 0, 4'd0);
    step(0, 0, 0, 0, 1, 4'd0);
    check_outs("carry_inflight", 4'd0, 1'b1, 1'b1);
    RST = 1'b1;
    #1;
    check_outs("carry_dropped", 4'd0, 1'b0, 1'b0);
    @(negedge CLK_IN);
    RST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
